reg_dump_tx: RTL

REG_DUMP_TX -- requirements
Module: reg_dump_tx

---
 rtl/reg_dump_tx.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/reg_dump_tx.sv
// reg_dump_tx: walks register addresses 0..NREGS-1, reads each word from an
// asynchronous register-file port and sends it as an 8N1-style serial frame
// (start bit, N data bits LSB first, stop bit), CLKS_PER_BIT clocks per bit.
// Optional build macro REG_DUMP_HEADER_EN: each dump is preceded by one
// header frame carrying 8'hA5 (zero-extended to N bits).
module reg_dump_tx #(
  parameter int unsigned N            = 8,
  parameter int unsigned NREGS        = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [4:0]   ra,
  input  logic [N-1:0] rd,
  output logic         tx,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
  localparam logic [4:0]    RA_LAST  = 5'(NREGS - 1);
`ifdef REG_DUMP_HEADER_EN
  localparam logic [N-1:0]  HDR_WORD = N'(8'hA5);
`endif

  typedef enum logic [2:0] {IDLE, ADDR, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] clk_cnt, clk_cnt_nxt;
  logic [BW-1:0] bit_cnt, bit_cnt_nxt;
  logic [N-1:0]  shreg, shreg_nxt, sh_dn;
  logic [4:0]    ra_nxt;
  logic          tx_nxt, busy_nxt, done_nxt;
`ifdef REG_DUMP_HEADER_EN
  logic          hdr, hdr_nxt;
`endif

  // State and output registers; synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      ra      <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef REG_DUMP_HEADER_EN
      hdr     <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      clk_cnt <= clk_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      ra      <= ra_nxt;
      tx      <= tx_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
`ifdef REG_DUMP_HEADER_EN
      hdr     <= hdr_nxt;
`endif
    end
  end

  // Next-state and next-output logic; tx_nxt is the line level of the next state
  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    ra_nxt      = ra;
    tx_nxt      = tx;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    sh_dn       = shreg >> 1;
`ifdef REG_DUMP_HEADER_EN
    hdr_nxt     = hdr;
`endif
    case (state)
      IDLE: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
        // a start arriving alongside the done pulse belongs to the old dump
        if (start && !done) begin
          ra_nxt    = '0;
          busy_nxt  = 1'b1;
          state_nxt = ADDR;
`ifdef REG_DUMP_HEADER_EN
          hdr_nxt   = 1'b1;
`endif
        end
      end
      ADDR: begin
`ifdef REG_DUMP_HEADER_EN
        shreg_nxt   = hdr ? HDR_WORD : rd;
`else
        shreg_nxt   = rd;
`endif
        clk_cnt_nxt = '0;
        tx_nxt      = 1'b0;
        state_nxt   = START;
      end
      START: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_nxt = '0;
          bit_cnt_nxt = '0;
          tx_nxt      = shreg[0];
          state_nxt   = DATA;
        end else begin
          clk_cnt_nxt = clk_cnt + CW'(1);
        end
      end
      DATA: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_nxt = '0;
          if (bit_cnt == BIT_LAST) begin
            tx_nxt    = 1'b1;
            state_nxt = STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + BW'(1);
            shreg_nxt   = sh_dn;
            tx_nxt      = sh_dn[0];
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CW'(1);
        end
      end
      STOP: begin
        tx_nxt = 1'b1;
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_nxt = '0;
`ifdef REG_DUMP_HEADER_EN
          if (hdr) begin
            hdr_nxt   = 1'b0;
            state_nxt = ADDR;
          end else
`endif
          if (ra == RA_LAST) begin
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end else begin
            ra_nxt    = ra + 5'd1;
            state_nxt = ADDR;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule
